instrreq: RTL and testbench

Instruction-fetch request engine on the producer side of the fetch-line interface. Turns redirects into line-aligned instruction-memory reads, absorbs returning lines in a small skid FIFO, and delivers them as `line_vld`/`line_data` under `buffer_free` back-pressure. Sits between the instruction-memory port and the fetch-line buffer. On every redirect it issues `jump_vld`/`jump_pc` and discards stale in-flight responses.

---
 rtl/instrreq_pkg.sv | 18 +
 rtl/instr_skid_fifo.sv | 56 +++++
 rtl/instrreq.sv | 104 ++++++++++
 tb/tb_instrreq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instrreq_pkg.sv
// Shared constants and helpers for the instruction-fetch request engine.
package instrreq_pkg;

    localparam int XLEN_DFLT     = 32;
    localparam int BUS_LEN_DFLT  = 2;
    localparam int FETCH_MAX_OUT = 2;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Byte-offset bits inside one fetch line of bus_len 32-bit words.
    function automatic int line_off_bits(input int bus_len);
        return $clog2(bus_len) + 2;
    endfunction

endpackage

// File: rtl/instr_skid_fifo.sv
// Skid FIFO holding returned fetch lines; synchronous flush wins over push.
module instr_skid_fifo
    import instrreq_pkg::*;
#(
    parameter int DEPTH = FETCH_MAX_OUT,
    parameter int WIDTH = 64,
    parameter int CNT_W = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Line storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign cnt   = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/instrreq.sv
// Instruction-fetch request engine: redirects -> line-aligned imem reads -> fetch lines.
// Optional INSTR_SKID_BYPASS_EN: fresh response into an empty FIFO is delivered same cycle.
module instrreq
    import instrreq_pkg::*;
#(
    parameter int              XLEN     = XLEN_DFLT,
    parameter int              BUS_LEN  = BUS_LEN_DFLT,
    parameter int              BUS_WID  = BUS_LEN * XLEN,
    parameter int              MAX_OUT  = FETCH_MAX_OUT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_jump_vld,
    input  logic [XLEN-1:0]    sys_jump_pc,
    input  logic               buffer_free,
    output logic               jump_vld,
    output logic [XLEN-1:0]    jump_pc,
    output logic               line_vld,
    output logic [BUS_WID-1:0] line_data,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rdy,
    input  logic               imem_resp,
    input  logic [BUS_WID-1:0] imem_rdata
);

    localparam int              OFF_W     = line_off_bits(BUS_LEN);
    localparam int              CNT_W     = cnt_bits(MAX_OUT);
    localparam int              SUM_W     = CNT_W + 1;
    localparam logic [XLEN-1:0] LINE_MASK = {XLEN{1'b1}} << OFF_W;
    localparam logic [XLEN-1:0] LINE_STEP = XLEN'(BUS_LEN * 4);

    logic [XLEN-1:0]    fetch_addr;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic [BUS_WID-1:0] fifo_head;
    logic               accept;
    logic               fresh;
    logic               fifo_line;
    logic               bypass;
    logic               push;

    // A response is stale while old requests remain or when a redirect lands with it.
    assign fresh     = imem_resp & (drop_cnt == '0) & !sys_jump_vld;
    assign imem_req  = rst & !sys_jump_vld
                     & ((SUM_W'(out_cnt) + SUM_W'(fifo_cnt)) < SUM_W'(MAX_OUT));
    assign imem_addr = fetch_addr;
    assign accept    = imem_req & imem_rdy;
    assign fifo_line = !fifo_empty & buffer_free & !jump_vld;

`ifdef INSTR_SKID_BYPASS_EN
    assign bypass    = fresh & fifo_empty & buffer_free & !jump_vld;
    assign line_vld  = fifo_line | bypass;
    assign line_data = bypass ? imem_rdata : (fifo_line ? fifo_head : '0);
`else
    assign bypass    = 1'b0;
    assign line_vld  = fifo_line;
    assign line_data = fifo_line ? fifo_head : '0;
`endif

    assign push = fresh & !bypass;

    instr_skid_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (BUS_WID),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_line),
        .flush (sys_jump_vld),
        .din   (imem_rdata),
        .dout  (fifo_head),
        .cnt   (fifo_cnt),
        .empty (fifo_empty)
    );

    // jump_vld resets high so the downstream buffer is pointed at RESET_PC on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr <= RESET_PC & LINE_MASK;
            out_cnt    <= '0;
            drop_cnt   <= '0;
            jump_vld   <= 1'b1;
            jump_pc    <= RESET_PC;
        end else begin
            jump_vld <= sys_jump_vld;
            out_cnt  <= out_cnt + CNT_W'(accept) - CNT_W'(imem_resp);
            if (sys_jump_vld) begin
                jump_pc    <= sys_jump_pc;
                fetch_addr <= sys_jump_pc & LINE_MASK;
                drop_cnt   <= out_cnt - CNT_W'(imem_resp);
            end else begin
                if (accept) fetch_addr <= fetch_addr + LINE_STEP;
                if (imem_resp && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instrreq.sv
// Self-checking bench for instrreq: epoch-tagged stream model plus directed scenarios.
module tb_instrreq;

    localparam int          XLEN    = 32;
    localparam int          BUS_LEN = 2;
    localparam int          BUS_WID = 64;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h100;
    localparam logic [31:0] MASK    = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY     = 32'hC0DE_0000;
`ifdef INSTR_SKID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sys_jump_vld = 1'b0;
    logic [XLEN-1:0]    sys_jump_pc = '0;
    logic               buffer_free = 1'b1;
    logic               jump_vld;
    logic [XLEN-1:0]    jump_pc;
    logic               line_vld;
    logic [BUS_WID-1:0] line_data;
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_rdy = 1'b1;
    logic               imem_resp = 1'b0;
    logic [BUS_WID-1:0] imem_rdata = '0;

    instrreq #(
        .XLEN(XLEN), .BUS_LEN(BUS_LEN), .BUS_WID(BUS_WID),
        .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst(rst), .sys_jump_vld(sys_jump_vld), .sys_jump_pc(sys_jump_pc),
        .buffer_free(buffer_free), .jump_vld(jump_vld), .jump_pc(jump_pc),
        .line_vld(line_vld), .line_data(line_data), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_resp(imem_resp),
        .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [63:0] data; int cyc; } del_t;
    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    del_t        del_log[$];
    logic [31:0] jmp_log[$];

    // Model state: request epochs, undelivered current-epoch lines, next expected addresses.
    int          epoch;
    int          req_ep[$];
    int          held;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_del_addr;
    bit          jump_pending;
    logic [31:0] jump_target;

    function automatic logic [63:0] line_of(input logic [31:0] a);
        return {(a + 32'd4) ^ KEY, a ^ KEY};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic missing(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event never observed (cycle %0d)", nm, cyc);
    endtask

    // Memory: in-order responses a fixed latency after acceptance.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            mq.delete();
            imem_resp = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp  = 1'b1;
            imem_rdata = line_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        bit fresh, e_jump, e_req, byp, e_line;
        if (!rst) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_jump_vld", jump_vld, 1);
            chk("rst_jump_pc", jump_pc, RST_PC);
            chk("rst_line_vld", line_vld, 0);
            chk("rst_line_data", line_data, 0);
            epoch = 0; req_ep.delete(); held = 0;
            exp_req_addr = RST_PC & MASK; exp_del_addr = RST_PC & MASK;
            jump_pending = 1'b1; jump_target = RST_PC;
        end else begin
            if (imem_resp && req_ep.size() == 0) missing("resp_without_outstanding_request");
            fresh  = imem_resp && req_ep.size() > 0 && req_ep[0] == epoch && !sys_jump_vld;
            e_jump = jump_pending;
            e_req  = !sys_jump_vld && (req_ep.size() + held < MAX_OUT);
            byp    = BYP && fresh && held == 0 && buffer_free && !e_jump;
            e_line = !e_jump && buffer_free && (held > 0 || byp);
            chk("jump_vld", jump_vld, e_jump);
            chk("imem_req", imem_req, e_req);
            chk("line_vld", line_vld, e_line);
            chk("line_jump_overlap", line_vld & jump_vld, 0);
            if (jump_vld && e_jump) begin
                chk("jump_pc", jump_pc, jump_target);
                jmp_log.push_back(jump_pc);
            end
            if (line_vld && e_line) begin
                chk("line_data", line_data, line_of(exp_del_addr));
                del_log.push_back('{line_data, cyc});
            end
            if (imem_req && imem_rdy) begin
                chk("imem_addr", imem_addr, exp_req_addr);
                acc_log.push_back(imem_addr);
                mq.push_back('{imem_addr, cyc + lat});
            end
            if (imem_resp && req_ep.size() > 0) void'(req_ep.pop_front());
            if (e_line) begin
                exp_del_addr += 32'd8;
                if (!byp) held--;
            end
            if (fresh && !byp) held++;
            if (e_req && imem_rdy) begin
                req_ep.push_back(epoch);
                exp_req_addr += 32'd8;
            end
            if (sys_jump_vld) begin
                epoch++; held = 0;
                exp_req_addr = sys_jump_pc & MASK; exp_del_addr = sys_jump_pc & MASK;
                jump_pending = 1'b1; jump_target = sys_jump_pc;
            end else begin
                jump_pending = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] pc);
        @(posedge clk); #1;
        sys_jump_vld = 1'b1; sys_jump_pc = pc;
        @(posedge clk); #1;
        sys_jump_vld = 1'b0;
    endtask

    task automatic chk_acc(input string nm, input int idx, input logic [31:0] exp);
        if (acc_log.size() > idx) chk(nm, acc_log[idx], exp); else missing(nm);
    endtask

    task automatic chk_del(input string nm, input int idx, input logic [63:0] exp);
        if (del_log.size() > idx) chk(nm, del_log[idx].data, exp); else missing(nm);
    endtask

    task automatic chk_jmp(input string nm, input int idx, input logic [31:0] exp);
        if (jmp_log.size() > idx) chk(nm, jmp_log[idx], exp); else missing(nm);
    endtask

    initial begin
        int a, d, j;
        bit found;
        step(3);
        rst = 1'b1;

        // Reset release, 1-cycle memory: sequential lines from 0x100.
        step(12);
        chk_jmp("boot_jump_pc", 0, 32'h100);
        chk_acc("boot_req0", 0, 32'h100);
        chk_acc("boot_req1", 1, 32'h108);
        chk_acc("boot_req2", 2, 32'h110);
        chk_del("boot_line0", 0, 64'hC0DE0104_C0DE0100);
        chk_del("boot_line1", 1, 64'hC0DE010C_C0DE0108);
        chk_del("boot_line2", 2, 64'hC0DE0114_C0DE0110);

        // Redirect with two slow requests in flight.
        lat = 3;
        step(8);
        jump(32'h206);
        a = acc_log.size(); d = del_log.size(); j = jmp_log.size();
        step(14);
        chk_jmp("redir_jump_pc", j, 32'h206);
        chk_acc("redir_first_req", a, 32'h200);
        chk_del("redir_first_line", d, 64'hC0DE0204_C0DE0200);

        // Back-pressure for 10 cycles, then release.
        buffer_free = 1'b0;
        a = acc_log.size(); d = del_log.size();
        step(10);
        chk("bp_accepts_le_max", (acc_log.size() - a) <= MAX_OUT, 1);
        chk("bp_no_delivery", del_log.size() - d, 0);
        buffer_free = 1'b1;
        step(4);
        if (del_log.size() > d + 1) chk("bp_release_consecutive", del_log[d + 1].cyc - del_log[d].cyc, 1);
        else missing("bp_release_consecutive");

        // Redirect in the same cycle as a response.
        lat = 1;
        step(4);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #2;
            if (imem_resp) found = 1'b1;
        end
        if (!found) missing("resp_for_collision");
        sys_jump_vld = 1'b1; sys_jump_pc = 32'h3F2;
        @(posedge clk); #1;
        sys_jump_vld = 1'b0;
        a = acc_log.size(); d = del_log.size(); j = jmp_log.size();
        step(10);
        chk_jmp("coll_jump_pc", j, 32'h3F2);
        chk_acc("coll_first_req", a, 32'h3F0);
        chk_del("coll_first_line", d, 64'hC0DE03F4_C0DE03F0);

        // Memory stalled, then redirect.
        imem_rdy = 1'b0;
        step(5);
        jump(32'h1000_000A);
        imem_rdy = 1'b1;
        a = acc_log.size(); d = del_log.size(); j = jmp_log.size();
        step(10);
        chk_jmp("stall_jump_pc", j, 32'h1000_000A);
        chk_acc("stall_first_req", a, 32'h1000_0008);
        chk_del("stall_first_line", d, 64'hD0DE000C_D0DE0008);

        // Back-to-back redirects: both pulse, last target wins.
        j = jmp_log.size();
        @(posedge clk); #1;
        sys_jump_vld = 1'b1; sys_jump_pc = 32'h500;
        @(posedge clk); #1;
        sys_jump_pc = 32'h64C;
        @(posedge clk); #1;
        sys_jump_vld = 1'b0;
        a = acc_log.size(); d = del_log.size();
        step(10);
        chk_jmp("b2b_jump0", j, 32'h500);
        chk_jmp("b2b_jump1", j + 1, 32'h64C);
        chk_acc("b2b_first_req", a, 32'h648);
        chk_del("b2b_first_line", d, 64'hC0DE064C_C0DE0648);

        // Address wrap at the top of the space.
        jump(32'hFFFF_FFFA);
        a = acc_log.size(); d = del_log.size();
        step(12);
        chk_acc("wrap_req0", a, 32'hFFFF_FFF8);
        chk_acc("wrap_req1", a + 1, 32'h0000_0000);
        chk_del("wrap_line0", d, 64'h3F21FFFC_3F21FFF8);
        chk_del("wrap_line1", d + 1, 64'hC0DE0004_C0DE0000);

        step(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
